burst_req_tx: RTL and testbench

- Initiator-side serializer for the burst protocol.
- Accepts a parallel request: mode, burst length and start address.
- Drives en/mode_sel and shifts burst length and start address MSB-first onto two serial lines for the burst controller's serial-to-parallel receivers.
- Then tracks returned address beats until the burst completes or the receiver signals stop, and reports done to the requester.

---
 rtl/burst_req_tx_if.sv | 38 +++
 rtl/burst_req_tx.sv | 184 ++++++++++++++++++
 tb/tb_burst_req_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/burst_req_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : burst_req_tx_if
//  Purpose  : Request/serial bundle between a requester, burst_req_tx and
//             the burst controller's serial receivers.
//             slave  = burst_req_tx side, master = requester/receiver side.
//  Revision : 1.0  initial release
// ============================================================================
interface burst_req_tx_if #(
    parameter int LEN_W  = 4,
    parameter int ADDR_W = 20
);
    logic              req;
    logic              req_mode;
    logic [LEN_W-1:0]  req_len;
    logic [ADDR_W-1:0] req_addr;
    logic              abort;
    logic              beat_valid;
    logic              stop_signal;
    logic              busy;
    logic              en;
    logic              mode_sel;
    logic              len_sdo;
    logic              addr_sdo;
    logic              done;
    logic [LEN_W-1:0]  beat_cnt;

    modport slave (
        input  req, req_mode, req_len, req_addr, abort, beat_valid, stop_signal,
        output busy, en, mode_sel, len_sdo, addr_sdo, done, beat_cnt
    );

    modport master (
        output req, req_mode, req_len, req_addr, abort, beat_valid, stop_signal,
        input  busy, en, mode_sel, len_sdo, addr_sdo, done, beat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/burst_req_tx.sv
`default_nettype none
// ============================================================================
//  Module   : burst_req_tx
//  Purpose  : Initiator-side burst request serialiser. Latches mode, length
//             and start address, shifts length/address MSB-first on two
//             serial lines, then counts returned address beats until the
//             burst completes or the receiver signals stop.
//  Options  : BURST_TX_PARITY_EN - appends one even-parity cycle to SHIFT.
//  Revision : 1.0  initial release
// ============================================================================
module burst_req_tx #(
    parameter int LEN_W  = 4,
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 6
) (
    input  logic           clk,
    input  logic           rst,     // asynchronous, active-low
    burst_req_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef BURST_TX_PARITY_EN
    // One extra SHIFT cycle carries the parity bits after the last address bit.
    localparam logic [CNT_W-1:0] c_K_LAST = CNT_W'(ADDR_W);
`else
    localparam logic [CNT_W-1:0] c_K_LAST = CNT_W'(ADDR_W - 1);
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_sh;
    logic [LEN_W-1:0]  r_len_sh;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_k;
    logic              r_mode;
    logic              r_busy;
    logic              r_en;
    logic              r_mode_sel;
    logic              r_len_sdo;
    logic              r_addr_sdo;
    logic              r_done;
`ifdef BURST_TX_PARITY_EN
    logic              r_addr_par;
    logic              r_len_par;
`endif

    // A zero-length burst request degrades to a single transfer.
    logic              w_req_mode_eff;
    // Beats saturate at the latched length.
    logic              w_beat;
    logic [LEN_W-1:0]  w_cnt_next;

    assign w_req_mode_eff = bus.req_mode && (bus.req_len != '0);
    assign w_beat         = bus.beat_valid && (r_cnt != r_len);
    assign w_cnt_next     = r_cnt + LEN_W'(w_beat);

    // Transaction sequencer: latch, serialise, count beats; all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_addr_sh  <= '0;
            r_len_sh   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_en       <= 1'b0;
            r_mode_sel <= 1'b0;
            r_len_sdo  <= 1'b0;
            r_addr_sdo <= 1'b0;
            r_done     <= 1'b0;
`ifdef BURST_TX_PARITY_EN
            r_addr_par <= 1'b0;
            r_len_par  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        // First serial bit goes out together with the latch.
                        r_state    <= S_SHIFT;
                        r_mode     <= w_req_mode_eff;
                        r_len      <= bus.req_len;
                        r_addr_sh  <= {bus.req_addr[ADDR_W-2:0], 1'b0};
                        r_len_sh   <= {bus.req_len[LEN_W-2:0], 1'b0};
                        r_k        <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_en       <= 1'b1;
                        r_mode_sel <= w_req_mode_eff;
                        r_addr_sdo <= bus.req_addr[ADDR_W-1];
                        r_len_sdo  <= bus.req_len[LEN_W-1];
`ifdef BURST_TX_PARITY_EN
                        r_addr_par <= ^bus.req_addr;
                        r_len_par  <= ^bus.req_len;
`endif
                    end
                end
                S_SHIFT: begin
                    if (bus.abort) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_en       <= 1'b0;
                        r_mode_sel <= 1'b0;
                        r_len_sdo  <= 1'b0;
                        r_addr_sdo <= 1'b0;
                    end else if (r_k == c_K_LAST) begin
                        r_len_sdo  <= 1'b0;
                        r_addr_sdo <= 1'b0;
                        if (r_mode) begin
                            r_state    <= S_BURST;
                            r_mode_sel <= 1'b1;
                        end else begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_en       <= 1'b0;
                            r_mode_sel <= 1'b0;
                        end
                    end else begin
                        r_k <= r_k + CNT_W'(1);
`ifdef BURST_TX_PARITY_EN
                        if (r_k == CNT_W'(ADDR_W - 1)) begin
                            r_addr_sdo <= r_addr_par;
                            r_len_sdo  <= r_len_par;
                        end else begin
                            r_addr_sdo <= r_addr_sh[ADDR_W-1];
                            r_len_sdo  <= r_len_sh[LEN_W-1];
                        end
`else
                        r_addr_sdo <= r_addr_sh[ADDR_W-1];
                        r_len_sdo  <= r_len_sh[LEN_W-1];
`endif
                        // Zero fill makes len_sdo idle low once the length is out.
                        r_addr_sh <= {r_addr_sh[ADDR_W-2:0], 1'b0};
                        r_len_sh  <= {r_len_sh[LEN_W-2:0], 1'b0};
                    end
                end
                S_BURST: begin
                    if (bus.abort) begin
                        // Abort wins over a same-cycle beat: count is held.
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_en       <= 1'b0;
                        r_mode_sel <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if ((w_cnt_next == r_len) || bus.stop_signal) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_en       <= 1'b0;
                            r_mode_sel <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.en       = r_en;
    assign bus.mode_sel = r_mode_sel;
    assign bus.len_sdo  = r_len_sdo;
    assign bus.addr_sdo = r_addr_sdo;
    assign bus.done     = r_done;
    assign bus.beat_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_burst_req_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_burst_req_tx
//  Purpose  : Self-checking bench for burst_req_tx. A per-transaction
//             reference model predicts every output cycle by cycle from the
//             request fields and the driven beat/stop/abort pattern.
//  Options  : BURST_TX_PARITY_EN - expects the trailing parity cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_burst_req_tx;

    localparam int LEN_W  = 4;
    localparam int ADDR_W = 20;
    localparam int CNT_W  = 6;
`ifdef BURST_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SL = ADDR_W + PAR;   // cycles spent serialising
    localparam int NO_STOP = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    burst_req_tx_if #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus();

    burst_req_tx #(.LEN_W(LEN_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {busy, en, mode_sel, len_sdo, addr_sdo, done, beat_cnt}
    logic [9:0] outs;
    assign outs = {bus.busy, bus.en, bus.mode_sel, bus.len_sdo, bus.addr_sdo, bus.done, bus.beat_cnt};

    typedef struct {
        logic        mode;
        logic [3:0]  len;
        logic [19:0] addr;
        int          abort_at;
        int          stop_beats;
        bit          rnd;
        bit          spam;
        int          exp_done;
        int          exp_tdone;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic zero_inputs();
        bus.req = 1'b0; bus.req_mode = 1'b0; bus.req_len = '0; bus.req_addr = '0;
        bus.abort = 1'b0; bus.beat_valid = 1'b0; bus.stop_signal = 1'b0;
    endtask

    // Runs one transaction starting just after a rising edge in IDLE.
    // Phases of the model: 0 serialising, 1 collecting beats, 2 done pulse, 3 idle.
    task automatic run_txn(input string tag, input logic mode, input logic [3:0] len,
                           input logic [19:0] addr, input int abort_at, input int stop_beats,
                           input bit rnd, input bit spam,
                           output int n_done, output int t_done, output logic [3:0] got_cnt);
        bit         eff;
        int         phase;
        int         cyc;
        logic [3:0] c;
        logic       bv, st, ab, lb, adb;
        logic [9:0] exp;
        eff = mode && (len != 4'd0);
        c = 4'd0; phase = 0; cyc = 1; n_done = 0; t_done = 0; got_cnt = 4'd0;
        bus.req = 1'b1; bus.req_mode = mode; bus.req_len = len; bus.req_addr = addr;
        @(posedge clk); #1;
        bus.req = 1'b0;
        while (cyc < 200) begin
            bv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            st = (phase == 1) && (stop_beats != NO_STOP) && (int'(c) >= stop_beats);
            if (st && !rnd) bv = 1'b0;
            ab = (cyc == abort_at) && (phase < 3);
            bus.beat_valid  = bv;
            bus.stop_signal = st;
            bus.abort       = ab;
            if (spam && phase < 3) begin
                bus.req      = 1'($urandom_range(0, 1));
                bus.req_mode = 1'($urandom_range(0, 1));
                bus.req_len  = 4'($urandom);
                bus.req_addr = 20'($urandom);
            end else begin
                bus.req = 1'b0;
            end
            @(negedge clk);
            case (phase)
                0: begin
                    adb = (cyc <= ADDR_W) ? addr[ADDR_W-cyc] : ^addr;
                    lb  = (cyc <= LEN_W) ? len[LEN_W-cyc] :
                          ((cyc == ADDR_W + 1) ? ^len : 1'b0);
                    exp = {1'b1, 1'b1, eff, lb, adb, 1'b0, 4'd0};
                end
                1:       exp = {3'b111, 2'b00, 1'b0, c};
                2:       exp = {5'b00000, 1'b1, c};
                default: exp = {6'b000000, c};
            endcase
            chk($sformatf("%s cyc%0d ph%0d outs", tag, cyc, phase), 32'(outs), 32'(exp));
            if (bus.done) begin
                n_done++;
                t_done = cyc;
            end
            if (phase == 3) begin
                got_cnt = bus.beat_cnt;
                break;
            end
            @(posedge clk); #1;
            case (phase)
                0: if (ab) phase = 3; else if (cyc == SL) phase = eff ? 1 : 2;
                1: if (ab) phase = 3;
                   else begin
                       if (bv && c < len) c = c + 4'd1;
                       if (c == len || st) phase = 2;
                   end
                default: phase = 3;
            endcase
            cyc++;
        end
        if (phase != 3) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no return to idle required idle within 200 cycles", tag);
        end
        zero_inputs();
        @(posedge clk); #1;
    endtask

    initial begin : main
        int         nd, td;
        logic [3:0] gc;
        logic [3:0] rl;
        vec_t       v;

        //        mode  len     addr      abort  stop     rnd spam done tdone  cnt
        vecs[0]  = '{1'b0, 4'd0,  20'hA5F3C, 0,    NO_STOP, 0, 0,  1, SL+1,  4'd0};
        vecs[1]  = '{1'b1, 4'd11, 20'h00010, 0,    NO_STOP, 0, 0,  1, SL+12, 4'd11};
        vecs[2]  = '{1'b1, 4'd8,  20'h12345, 0,    3,       0, 0,  1, SL+5,  4'd3};
        vecs[3]  = '{1'b1, 4'd0,  20'hFFFFF, 0,    NO_STOP, 0, 0,  1, SL+1,  4'd0};
        vecs[4]  = '{1'b1, 4'd5,  20'hABCDE, 8,    NO_STOP, 0, 0,  0, 0,     4'd0};
        vecs[5]  = '{1'b0, 4'd3,  20'h0F0F0, 0,    NO_STOP, 0, 1,  1, SL+1,  4'd0};
        vecs[6]  = '{1'b1, 4'd9,  20'h55555, SL+3, NO_STOP, 0, 0,  0, 0,     4'd2};
        vecs[7]  = '{1'b1, 4'd15, 20'hFFFFF, 0,    NO_STOP, 0, 1,  1, SL+16, 4'd15};
        vecs[8]  = '{1'b1, 4'd6,  20'h80001, 0,    0,       0, 0,  1, SL+2,  4'd0};
        vecs[9]  = '{1'b1, 4'd1,  20'h00001, 0,    NO_STOP, 0, 0,  1, SL+2,  4'd1};
        vecs[10] = '{1'b0, 4'd7,  20'h7FFFF, 1,    NO_STOP, 0, 0,  0, 0,     4'd0};
        vecs[11] = '{1'b0, 4'd2,  20'h00001, SL,   NO_STOP, 0, 0,  0, 0,     4'd0};

        zero_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(outs), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_reset", 32'(outs), 32'd0);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            run_txn($sformatf("vec%0d", i), v.mode, v.len, v.addr, v.abort_at, v.stop_beats,
                    v.rnd, v.spam, nd, td, gc);
            chk($sformatf("vec%0d done_pulses", i), 32'(nd), 32'(v.exp_done));
            chk($sformatf("vec%0d done_cycle", i), 32'(td), 32'(v.exp_tdone));
            chk($sformatf("vec%0d beat_cnt", i), 32'(gc), 32'(v.exp_cnt));
        end

        // beat_cnt holds in IDLE; abort/beat/stop there are ignored
        run_txn("hold", 1'b1, 4'd6, 20'h3C3C3, 0, NO_STOP, 0, 0, nd, td, gc);
        for (int i = 0; i < 3; i++) begin
            bus.beat_valid = 1'b1; bus.abort = 1'b1; bus.stop_signal = 1'b1;
            @(negedge clk);
            chk($sformatf("idle_hold%0d", i), 32'(outs), 32'({6'b000000, 4'd6}));
            @(posedge clk); #1;
        end
        zero_inputs();

        // Asynchronous reset while in BURST
        bus.req = 1'b1; bus.req_mode = 1'b1; bus.req_len = 4'd15; bus.req_addr = 20'h5A5A5;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (SL + 2) @(posedge clk);
        #3;
        chk("pre_reset_burst", 32'(outs), 32'(10'b1110000000));
        rst = 1'b0;
        #2;
        chk("async_reset_immediate", 32'(outs), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("async_reset_held", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Randomised transactions against the model
        for (int i = 0; i < 40; i++) begin
            rl = 4'($urandom);
            run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), rl, 20'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SL + 8)) : 0,
                    ($urandom_range(0, 1) == 0) ? NO_STOP : int'($urandom_range(0, 15)),
                    1'b1, 1'($urandom_range(0, 1)), nd, td, gc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
